// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: keeps up to DEPTH fetched words (with their PCs) ahead of decode,
// one outstanding memory request at a time; redirects flush the queue and drop in-flight data.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       mem_req_o,
    output logic [31:0]                mem_addr_o,
    input  logic                       mem_ack_i,
    input  logic [31:0]                mem_data_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [31:0]    q_instr [DEPTH];
    logic [31:0]    q_pc    [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, count_next;
    logic [31:0]    redir_pc, next_pc;
    logic           ack, push, pop;
    logic           unused_pc_bits;

    assign redir_pc       = {redirect_pc_i[31:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc_i[1:0];
    assign next_pc        = fetch_pc + 32'd4;
    assign ack            = mem_ack_i & mem_req_o;
    assign push           = (state == REQ) & ack & ~redirect_i;
    assign pop            = instr_valid_o & instr_ready_i & ~redirect_i;
    assign count_next     = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    assign count_o       = count;
    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? q_instr[rd_ptr] : 32'h0;
    assign pc_o          = instr_valid_o ? q_pc[rd_ptr]    : 32'h0;

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_instr[wr_ptr] <= mem_data_i;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            mem_req_o  <= 1'b0;
            mem_addr_o <= 32'h0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            if (redirect_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count_next;
            end

            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        fetch_pc   <= redir_pc;
                        mem_addr_o <= redir_pc;
                        mem_req_o  <= 1'b1;
                        state      <= REQ;
                    end else if (count < FULL) begin
                        mem_addr_o <= fetch_pc;
                        mem_req_o  <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (redirect_i) begin
                        fetch_pc <= redir_pc;
                        if (ack) mem_addr_o <= redir_pc;
                        else     state      <= DROP;  // keep old address; response gets dropped
                    end else if (ack) begin
                        fetch_pc <= next_pc;
                        if (count_next < FULL) begin
                            mem_addr_o <= next_pc;
                        end else begin
                            mem_req_o <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                DROP: begin
                    // An ack completes the abandoned request even if another redirect lands with it.
                    if (redirect_i) fetch_pc <= redir_pc;
                    if (ack) begin
                        mem_addr_o <= redirect_i ? redir_pc : fetch_pc;
                        state      <= REQ;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
